// File: rtl/inst_sram_arb.sv
// Arbiter between instruction fetch (reads) and the program loader (writes)
// sharing a single inst_sram. Round-robin on contention; the loader lock excludes fetch.
module inst_sram_arb #(
    parameter int DEPTH = 128,
    parameter int AW    = 64
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          fe_req,
    input  logic [AW-1:0] fe_addr,
    output logic          fe_gnt,
    output logic          fe_rvalid,
    output logic [31:0]   fe_rdata,
    output logic          fe_err,

    input  logic          ld_lock,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_wdata,
    output logic          ld_gnt,
    output logic          ld_err,
    output logic [15:0]   ld_count,

    output logic          inst_sram_en,
    output logic          inst_sram_wen,
    output logic [AW-1:0] inst_sram_addr,
    output logic [AW-1:0] inst_sram_waddr,
    output logic [31:0]   inst_sram_wdata,
    input  logic [31:0]   inst_sram_rdata
);

    typedef enum logic {
        GNT_FE = 1'b0,
        GNT_LD = 1'b1
    } grant_e;

    localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

    grant_e        last_grant_q, last_grant_d;
    logic          fe_rvalid_q, fe_rvalid_d;
    logic          fe_err_q, fe_err_d;
    logic [31:0]   fe_rdata_q, fe_rdata_d;
    logic          ld_err_q, ld_err_d;
    logic [15:0]   ld_count_q, ld_count_d;

    logic [AW-1:0] fe_idx, ld_idx;
    logic          fe_ok, ld_ok;
    logic          fe_gnt_c, ld_gnt_c;

    assign fe_idx = fe_addr >> 2;
    assign ld_idx = ld_addr >> 2;
    assign fe_ok  = (fe_addr[1:0] == 2'b00) && (fe_idx < DEPTH_W);
    assign ld_ok  = (ld_addr[1:0] == 2'b00) && (ld_idx < DEPTH_W);

    // On contention the side that did not win the most recent grant goes next.
    always_comb begin
        fe_gnt_c     = 1'b0;
        ld_gnt_c     = 1'b0;
        last_grant_d = last_grant_q;
        if (!reset) begin
            if (ld_lock) begin
                ld_gnt_c = ld_req;
            end else if (fe_req && ld_req) begin
                if (last_grant_q == GNT_FE) ld_gnt_c = 1'b1;
                else                        fe_gnt_c = 1'b1;
            end else begin
                fe_gnt_c = fe_req;
                ld_gnt_c = ld_req;
            end
        end
        if (fe_gnt_c)      last_grant_d = GNT_FE;
        else if (ld_gnt_c) last_grant_d = GNT_LD;
    end

    always_comb begin
        fe_rvalid_d = fe_gnt_c;
        fe_err_d    = fe_gnt_c && !fe_ok;
        fe_rdata_d  = fe_rdata_q;
        if (fe_gnt_c) fe_rdata_d = fe_ok ? inst_sram_rdata : 32'h0;
        ld_err_d    = ld_gnt_c && !ld_ok;
        ld_count_d  = ld_count_q;
        if (ld_gnt_c && ld_ok && (ld_count_q != 16'hFFFF)) ld_count_d = ld_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= GNT_FE;
            fe_rvalid_q  <= 1'b0;
            fe_err_q     <= 1'b0;
            fe_rdata_q   <= 32'h0;
            ld_err_q     <= 1'b0;
            ld_count_q   <= 16'h0;
        end else begin
            last_grant_q <= last_grant_d;
            fe_rvalid_q  <= fe_rvalid_d;
            fe_err_q     <= fe_err_d;
            fe_rdata_q   <= fe_rdata_d;
            ld_err_q     <= ld_err_d;
            ld_count_q   <= ld_count_d;
        end
    end

    assign fe_gnt = fe_gnt_c;
    assign ld_gnt = ld_gnt_c;

    // Masking with reset kills a response pulse still in flight when reset arrives.
    assign fe_rvalid = fe_rvalid_q && !reset;
    assign fe_err    = fe_err_q && !reset;
    assign fe_rdata  = reset ? 32'h0 : fe_rdata_q;
    assign ld_err    = ld_err_q && !reset;
    assign ld_count  = reset ? 16'h0 : ld_count_q;

    assign inst_sram_en    = fe_gnt_c && fe_ok;
    assign inst_sram_addr  = inst_sram_en ? fe_idx : '0;
    assign inst_sram_wen   = ld_gnt_c && ld_ok;
    assign inst_sram_waddr = inst_sram_wen ? ld_idx : '0;
    assign inst_sram_wdata = inst_sram_wen ? ld_wdata : 32'h0;

endmodule

// File: tb/tb_inst_sram_arb.sv
// Directed bench for inst_sram_arb with a behavioural inst_sram model attached.
module tb_inst_sram_arb;
    localparam int DEPTH = 128;
    localparam int AW    = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          fe_req, fe_gnt, fe_rvalid, fe_err;
    logic [AW-1:0] fe_addr;
    logic [31:0]   fe_rdata;
    logic          ld_lock, ld_req, ld_gnt, ld_err;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_wdata;
    logic [15:0]   ld_count;
    logic          inst_sram_en, inst_sram_wen;
    logic [AW-1:0] inst_sram_addr, inst_sram_waddr;
    logic [31:0]   inst_sram_wdata, inst_sram_rdata;

    logic [31:0]   mem [DEPTH];
    int            total = 0;
    int            bad = 0;

    inst_sram_arb #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .fe_req(fe_req), .fe_addr(fe_addr), .fe_gnt(fe_gnt),
        .fe_rvalid(fe_rvalid), .fe_rdata(fe_rdata), .fe_err(fe_err),
        .ld_lock(ld_lock), .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_err(ld_err), .ld_count(ld_count),
        .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
        .inst_sram_addr(inst_sram_addr), .inst_sram_waddr(inst_sram_waddr),
        .inst_sram_wdata(inst_sram_wdata), .inst_sram_rdata(inst_sram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (inst_sram_wen) mem[inst_sram_waddr[6:0]] <= inst_sram_wdata;
    end
    assign inst_sram_rdata = mem[inst_sram_addr[6:0]];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic fr, input logic [AW-1:0] fa, input logic lk,
                         input logic lr, input logic [AW-1:0] la, input logic [31:0] lw);
        fe_req = fr; fe_addr = fa; ld_lock = lk; ld_req = lr; ld_addr = la; ld_wdata = lw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] rr_ld_exp;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, '0, 32'h0);
        repeat (2) tick();

        // Grants stay low while reset is held even with both requesting.
        drive(1'b1, '0, 1'b0, 1'b1, '0, 32'h0);
        @(negedge clk);
        check("rst_fe_gnt", 64'(fe_gnt), 64'(0));
        check("rst_ld_gnt", 64'(ld_gnt), 64'(0));
        check("rst_rvalid", 64'(fe_rvalid), 64'(0));
        check("rst_rdata", 64'(fe_rdata), 64'(0));
        check("rst_ld_err", 64'(ld_err), 64'(0));
        check("rst_ld_count", 64'(ld_count), 64'(0));
        tick();
        reset = 1'b0;

        // Locked load of four words with fetch requesting throughout.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, '0, 1'b1, 1'b1, 64'(i * 4), 32'h11111111 * 32'(i + 1));
            @(negedge clk);
            check("lock_fe_gnt", 64'(fe_gnt), 64'(0));
            check("lock_ld_gnt", 64'(ld_gnt), 64'(1));
            check("lock_wen", 64'(inst_sram_wen), 64'(1));
            check("lock_waddr", inst_sram_waddr, 64'(i));
            check("lock_wdata", 64'(inst_sram_wdata), 64'(32'h11111111 * 32'(i + 1)));
            tick();
        end
        check("lock_count", 64'(ld_count), 64'(4));

        // Back-to-back fetches: one response every cycle.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'(i * 4), 1'b0, 1'b0, '0, 32'h0);
            @(negedge clk);
            check("fe_gnt", 64'(fe_gnt), 64'(1));
            check("fe_en", 64'(inst_sram_en), 64'(1));
            check("fe_addr_idx", inst_sram_addr, 64'(i));
            tick();
            check("fe_rvalid", 64'(fe_rvalid), 64'(1));
            check("fe_rdata", 64'(fe_rdata), 64'(32'h11111111 * 32'(i + 1)));
            check("fe_err", 64'(fe_err), 64'(0));
        end
        drive(1'b0, '0, 1'b0, 1'b0, '0, 32'h0);
        @(negedge clk);
        check("idle_en", 64'(inst_sram_en), 64'(0));
        check("idle_addr", inst_sram_addr, 64'(0));
        check("idle_wen", 64'(inst_sram_wen), 64'(0));
        check("idle_wdata", 64'(inst_sram_wdata), 64'(0));
        tick();
        check("idle_rvalid", 64'(fe_rvalid), 64'(0));
        check("idle_rdata_hold", 64'(fe_rdata), 64'(32'h44444444));

        // Round robin after reset: ld,fe,ld,fe,ld,fe.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rr_ld_exp = 6'b010101;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, '0, 1'b0, 1'b1, 64'(32'h40 + i * 4), 32'hA0 + 32'(i));
            @(negedge clk);
            check("rr_ld_gnt", 64'(ld_gnt), 64'(rr_ld_exp[i]));
            check("rr_fe_gnt", 64'(fe_gnt), 64'(!rr_ld_exp[i]));
            tick();
        end
        check("rr_count", 64'(ld_count), 64'(3));

        // Write in cycle N is visible to a fetch in N+1.
        drive(1'b0, '0, 1'b0, 1'b1, 64'h20, 32'hDEADBEEF);
        tick();
        drive(1'b1, 64'h20, 1'b0, 1'b0, '0, 32'h0);
        tick();
        check("raw_rdata", 64'(fe_rdata), 64'(32'hDEADBEEF));
        check("raw_rvalid", 64'(fe_rvalid), 64'(1));

        // Highest in-range word.
        drive(1'b0, '0, 1'b0, 1'b1, 64'h1FC, 32'h7F7F7F7F);
        tick();
        drive(1'b1, 64'h1FC, 1'b0, 1'b0, '0, 32'h0);
        @(negedge clk);
        check("top_en", 64'(inst_sram_en), 64'(1));
        check("top_idx", inst_sram_addr, 64'(127));
        tick();
        check("top_rdata", 64'(fe_rdata), 64'(32'h7F7F7F7F));
        check("top_err", 64'(fe_err), 64'(0));
        check("top_count", 64'(ld_count), 64'(5));

        // Misaligned and out-of-range fetches.
        drive(1'b1, 64'h2, 1'b0, 1'b0, '0, 32'h0);
        @(negedge clk);
        check("mis_gnt", 64'(fe_gnt), 64'(1));
        check("mis_en", 64'(inst_sram_en), 64'(0));
        tick();
        check("mis_rvalid", 64'(fe_rvalid), 64'(1));
        check("mis_err", 64'(fe_err), 64'(1));
        check("mis_rdata", 64'(fe_rdata), 64'(0));
        drive(1'b1, 64'h200, 1'b0, 1'b0, '0, 32'h0);
        @(negedge clk);
        check("oor_en", 64'(inst_sram_en), 64'(0));
        check("oor_addr", inst_sram_addr, 64'(0));
        tick();
        check("oor_rvalid", 64'(fe_rvalid), 64'(1));
        check("oor_err", 64'(fe_err), 64'(1));
        check("oor_rdata", 64'(fe_rdata), 64'(0));

        // Out-of-range loader write is dropped.
        drive(1'b0, '0, 1'b0, 1'b1, 64'h200, 32'hCAFEF00D);
        @(negedge clk);
        check("ldoor_gnt", 64'(ld_gnt), 64'(1));
        check("ldoor_wen", 64'(inst_sram_wen), 64'(0));
        tick();
        check("ldoor_err", 64'(ld_err), 64'(1));
        check("ldoor_count", 64'(ld_count), 64'(5));
        drive(1'b0, '0, 1'b0, 1'b0, '0, 32'h0);
        tick();
        check("ldoor_err_pulse", 64'(ld_err), 64'(0));
        check("ldoor_rvalid", 64'(fe_rvalid), 64'(0));

        // Reset right after a fetch grant swallows the response.
        drive(1'b1, 64'h0, 1'b0, 1'b0, '0, 32'h0);
        tick();
        reset = 1'b1;
        drive(1'b1, '0, 1'b0, 1'b1, 64'h0, 32'h0);
        @(negedge clk);
        check("rst2_rvalid", 64'(fe_rvalid), 64'(0));
        check("rst2_count", 64'(ld_count), 64'(0));
        check("rst2_fe_gnt", 64'(fe_gnt), 64'(0));
        check("rst2_ld_gnt", 64'(ld_gnt), 64'(0));
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst2_first_ld", 64'(ld_gnt), 64'(1));
        check("rst2_first_fe", 64'(fe_gnt), 64'(0));
        tick();
        check("rst2_count_after", 64'(ld_count), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/inst_sram_arb.md
INST_SRAM_ARB -- requirements
Module: inst_sram_arb

Interface
REQ-001 SHALL have parameter DEPTH, default 128, meaning number of 32-bit words in the attached inst_sram.
REQ-002 SHALL have parameter AW, default 64, meaning address width of requester and SRAM address ports.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 fe_req  input  1  fetch read request.
REQ-006 fe_addr  input  AW  fetch byte address.
REQ-007 fe_gnt  output  1  fetch request accepted this cycle.
REQ-008 fe_rvalid  output  1  one-cycle pulse, fetch response valid.
REQ-009 fe_rdata  output  32  fetch read data, qualified by fe_rvalid.
REQ-010 fe_err  output  1  response is an error, qualified by fe_rvalid.
REQ-011 ld_lock  input  1  loader holds exclusive ownership; blocks fetch.
REQ-012 ld_req  input  1  loader write request.
REQ-013 ld_addr  input  AW  loader byte address.
REQ-014 ld_wdata  input  32  loader write data.
REQ-015 ld_gnt  output  1  loader write accepted this cycle.
REQ-016 ld_err  output  1  registered one-cycle pulse, previous accepted write was dropped.
REQ-017 ld_count  output  16  count of successful loader writes since reset, saturating.
REQ-018 inst_sram_en, inst_sram_wen  output  1 each  SRAM read enable, write enable.
REQ-019 inst_sram_addr, inst_sram_waddr  output  AW each  SRAM read and write word index.
REQ-020 inst_sram_wdata  output  32  SRAM write data; inst_sram_rdata  input  32  combinational SRAM read data.

Function
REQ-021 Word index SHALL be addr >> 2, zero-extended to AW; addr[1:0] != 0 is misaligned; index >= DEPTH is out of range.
REQ-022 At most one grant (fe_gnt or ld_gnt) SHALL be asserted per cycle; grants are combinational from requests and state.
REQ-023 ld_lock=1: only the loader is eligible; fe_gnt=0 regardless of fe_req.
REQ-024 ld_lock=0, exactly one requester: that requester is granted.
REQ-025 ld_lock=0, both requesting: grant goes to the requester not granted on the most recent grant (round-robin via last_grant register, updated on every grant).
REQ-026 Fetch grant, valid address: inst_sram_en=1, inst_sram_addr=index that cycle; rdata registered at edge; fe_rvalid=1, fe_err=0 next cycle (latency 1).
REQ-027 Fetch grant, misaligned or out of range: inst_sram_en=0; next cycle fe_rvalid=1, fe_err=1, fe_rdata=0.
REQ-028 Cycle after any cycle with fe_gnt=0: fe_rvalid=0, fe_rdata held at last value.
REQ-029 Loader grant, valid address: inst_sram_wen=1, inst_sram_waddr=index, inst_sram_wdata=ld_wdata that cycle; ld_count increments at edge, saturating at 16'hFFFF.
REQ-030 Loader grant, invalid address: inst_sram_wen=0; ld_count unchanged; ld_err=1 next cycle.
REQ-031 inst_sram_en and inst_sram_wen SHALL be 0 and SRAM address/data outputs 0 when no corresponding grant.
REQ-032 A write granted in cycle N SHALL be visible to a fetch granted in cycle N+1 (no bypass needed; SRAM write lands at edge).
REQ-033 Back-to-back fetch grants every cycle SHALL yield fe_rvalid every cycle (full throughput, no bubbles).

Reset
REQ-034 reset=1 SHALL force fe_rvalid=0, fe_err=0, fe_rdata=0, ld_err=0, ld_count=0, last_grant=fetch; grants are 0 during the reset cycle.
REQ-035 reset asserted in the cycle after a grant SHALL suppress the pending fe_rvalid/ld_err pulse.
REQ-036 After reset, the first contended cycle SHALL grant the loader.

Verification
REQ-037 Reset, ld_lock=1, loader writes 0x11111111..0x44444444 to addrs 0x0,0x4,0x8,0xC with fe_req=1 throughout -> fe_gnt never 1, ld_count=4.
REQ-038 ld_lock=0, fe_req to addrs 0x0..0xC on four consecutive cycles -> fe_rvalid on cycles 1-4 with data 0x11111111..0x44444444, fe_err=0.
REQ-039 Both requesting continuously for 6 cycles after reset -> grants alternate ld,fe,ld,fe,ld,fe.
REQ-040 Loader writes 0xDEADBEEF to 0x20 in cycle N, fetch 0x20 in N+1 -> fe_rdata=0xDEADBEEF in N+2.
REQ-041 fe_addr=0x2 and fe_addr=0x200 (DEPTH=128) -> fe_rvalid=1, fe_err=1, fe_rdata=0, inst_sram_en=0; ld_addr=0x200 -> ld_err pulse, ld_count unchanged.
REQ-042 Fetch granted, reset in next cycle -> fe_rvalid=0, ld_count=0, next contended cycle grants loader.
